// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM encoding, master indices
// and a saturating increment used by the optional perf counters.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int M_CPU  = 0;
    localparam int M_DMA  = 1;
    localparam int PERF_W = 16;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way request selector: round-robin on the last grant, or fixed priority
// to master 0 when fixed is set. Output is one-hot (or zero if no request).
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] sel
);

    always_comb begin
        sel = req;
        // last = 1 means master 1 was granted last, so master 0 takes the tie
        if (req == 2'b11) begin
            sel = (fixed || last) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM (IDLE/ACCESS/RESP).
// Define DMEM_ARB_PERF_EN to add saturating grant/conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_gnt0,
    output logic [PERF_W-1:0] perf_gnt1,
    output logic [PERF_W-1:0] perf_conflict
`endif
);

    arb_state_t        state_reg, state_next;
    logic              winner_reg, winner_next;
    logic              last_reg, last_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        rvalid_reg, rvalid_next;
    logic              mem_en_reg, mem_en_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] rdata_hold_reg [2];

    logic [1:0]        req;
    logic [1:0]        we_bits;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];
    logic [1:0]        sel;
    logic              sel_idx;

    assign req     = {m1_req, m0_req};
    assign we_bits = {m1_we, m0_we};
    assign addr_arr[M_CPU]  = m0_addr;
    assign addr_arr[M_DMA]  = m1_addr;
    assign wdata_arr[M_CPU] = m0_wdata;
    assign wdata_arr[M_DMA] = m1_wdata;

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_reg),
        .fixed (FIXED_PRIO != 0),
        .sel   (sel)
    );

    assign sel_idx = sel[M_DMA];

    always_comb begin
        state_next     = state_reg;
        winner_next    = winner_reg;
        last_next      = last_reg;
        gnt_next       = 2'b00;
        rvalid_next    = 2'b00;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (|sel) begin
                    winner_next    = sel_idx;
                    last_next      = sel_idx;
                    gnt_next       = sel;
                    mem_en_next    = 1'b1;
                    mem_we_next    = we_bits[sel_idx];
                    mem_addr_next  = addr_arr[sel_idx];
                    mem_wdata_next = wdata_arr[sel_idx];
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_we_reg) begin
                    state_next = IDLE;
                end else begin
                    rvalid_next[winner_reg] = 1'b1;
                    state_next              = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            winner_reg    <= 1'b0;
            last_reg      <= 1'b1;
            gnt_reg       <= 2'b00;
            rvalid_reg    <= 2'b00;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            winner_reg    <= winner_next;
            last_reg      <= last_next;
            gnt_reg       <= gnt_next;
            rvalid_reg    <= rvalid_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    // Each master's rdata shows the RAM live during its RESP cycle and holds it afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) rdata_hold_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rvalid_reg[i]) rdata_hold_reg[i] <= mem_rdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            assign rdata_arr[gi] = rvalid_reg[gi] ? mem_rdata : rdata_hold_reg[gi];
        end
    endgenerate

    assign m0_gnt    = gnt_reg[M_CPU];
    assign m1_gnt    = gnt_reg[M_DMA];
    assign m0_rvalid = rvalid_reg[M_CPU];
    assign m1_rvalid = rvalid_reg[M_DMA];
    assign m0_rdata  = rdata_arr[M_CPU];
    assign m1_rdata  = rdata_arr[M_DMA];
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_gnt0_reg, perf_gnt1_reg, perf_conflict_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0_reg     <= '0;
            perf_gnt1_reg     <= '0;
            perf_conflict_reg <= '0;
        end else begin
            if (gnt_reg[M_CPU]) perf_gnt0_reg <= sat_inc(perf_gnt0_reg);
            if (gnt_reg[M_DMA]) perf_gnt1_reg <= sat_inc(perf_gnt1_reg);
            if (state_reg == IDLE && (&req)) perf_conflict_reg <= sat_inc(perf_conflict_reg);
        end
    end

    assign perf_gnt0     = perf_gnt0_reg;
    assign perf_gnt1     = perf_gnt1_reg;
    assign perf_conflict = perf_conflict_reg;
`endif

endmodule
